// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the odd_even_merge_sort front end. This covers the
// sort word geometry, the field positions inside a word, the pad value for
// unused slots, and the frame loader state type.
//
// Sort word layout (29 bits, MSB first):
//   [28:24] idx     arrival slot number inside the frame
//   [23:22] cls     class label
//   [21:16] cnt     count field
//   [15:8]  key_hi  primary key
//   [7:0]   key_lo  secondary key
// -----------------------------------------------------------------------------
package sort_pkg;

  localparam int SORT_W     = 29;
  localparam int SORT_SLOTS = 32;
  localparam int SORT_IDX_W = $clog2(SORT_SLOTS);

  localparam int IDX_LSB = 24;
  localparam int IDX_W   = 5;
  localparam int CLS_LSB = 22;
  localparam int CLS_W   = 2;
  localparam int CNT_LSB = 16;
  localparam int CNT_W   = 6;
  localparam int KHI_LSB = 8;
  localparam int KHI_W   = 8;
  localparam int KLO_LSB = 0;
  localparam int KLO_W   = 8;

  typedef logic [SORT_W-1:0] sort_word_t;

  // All-ones pads sort to the top of an ascending network, so real words
  // always land in the low outputs.
  localparam sort_word_t SORT_PAD = '1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } load_state_t;

  // Recovers the arrival slot of a word after it has been through the sorter.
  function automatic logic [IDX_W-1:0] sort_idx_of(input sort_word_t w);
    return w[IDX_LSB +: IDX_W];
  endfunction

endpackage

// File: rtl/sort_key_pack.sv
// -----------------------------------------------------------------------------
// sort_key_pack
// Purely combinational builder of one sort word from its fields.
//
// Ports:
//   i_idx    in  5   arrival slot number
//   i_cls    in  2   class label
//   i_cnt    in  6   count field
//   i_khi    in  8   primary key
//   i_klo    in  8   secondary key
//   o_word   out 29  packed sort word
// -----------------------------------------------------------------------------
module sort_key_pack
  import sort_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  logic [CLS_W-1:0] i_cls,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [KHI_W-1:0] i_khi,
  input  logic [KLO_W-1:0] i_klo,
  output sort_word_t       o_word
);

  always_comb begin
    o_word                     = '0;
    o_word[IDX_LSB +: IDX_W]   = i_idx;
    o_word[CLS_LSB +: CLS_W]   = i_cls;
    o_word[CNT_LSB +: CNT_W]   = i_cnt;
    o_word[KHI_LSB +: KHI_W]   = i_khi;
    o_word[KLO_LSB +: KLO_W]   = i_klo;
  end

endmodule

// File: rtl/sort_frame_loader.sv
// -----------------------------------------------------------------------------
// sort_frame_loader
// Collects a serial valid/ready stream of pixel records into a frame of up
// to 32 sort words and hands the frame to the combinational sorter in
// parallel. Each word carries its arrival slot in the index field. A frame
// closes on in_last or on the 32nd word, and unused slots read as PAD_WORD.
//
// Ports:
//   clk          in   1        clock, rising edge
//   rst          in   1        synchronous active-high reset
//   in_valid     in   1        record valid
//   in_ready     out  1        loader accepts a record this cycle
//   in_cls       in   2        class label
//   in_cnt       in   6        count field
//   in_key_hi    in   8        primary key
//   in_key_lo    in   8        secondary key
//   in_last      in   1        record closes the frame
//   frame_valid  out  1        a complete frame is held
//   frame_ready  in   1        sorter consumes the frame
//   frame_data   out  N*W      slot i at [i*W +: W], slot 0 -> sorter s1
//   frame_count  out  6        number of real words, 1..32 while held
// -----------------------------------------------------------------------------
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int         N_SLOTS  = SORT_SLOTS,
  parameter int         W        = SORT_W,
  parameter logic [W-1:0] PAD_WORD = SORT_PAD
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CLS_W-1:0]       in_cls,
  input  logic [CNT_W-1:0]       in_cnt,
  input  logic [KHI_W-1:0]       in_key_hi,
  input  logic [KLO_W-1:0]       in_key_lo,
  input  logic                   in_last,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [N_SLOTS*W-1:0]   frame_data,
  output logic [SORT_IDX_W:0]    frame_count
);

  load_state_t           r_state;
  load_state_t           w_state_nxt;
  // One bit wider than the slot index so a full frame reads back as 32.
  logic [SORT_IDX_W:0]   r_cnt;
  logic [W-1:0]          r_mem [N_SLOTS];

  logic                  w_accept;
  logic                  w_close;
  logic                  w_release;
  logic [N_SLOTS-1:0]    w_we;
  sort_word_t            w_word;

  sort_key_pack u_pack (
    .i_idx  (r_cnt[SORT_IDX_W-1:0]),
    .i_cls  (in_cls),
    .i_cnt  (in_cnt),
    .i_khi  (in_key_hi),
    .i_klo  (in_key_lo),
    .o_word (w_word)
  );

  assign w_accept  = in_valid && in_ready;
  assign w_close   = w_accept && (in_last || (r_cnt == (SORT_IDX_W+1)'(N_SLOTS-1)));
  assign w_release = frame_valid && frame_ready;

  always_comb begin
    w_we = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_we[i] = w_accept && (r_cnt[SORT_IDX_W-1:0] == SORT_IDX_W'(i));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FILL: if (w_close)     w_state_nxt = ST_HOLD;
      ST_HOLD: if (frame_ready) w_state_nxt = ST_FILL;
      default:                  w_state_nxt = ST_FILL;
    endcase
  end

  // Outputs depend on the registered state only, never on the inputs.
  always_comb begin
    in_ready    = 1'b0;
    frame_valid = 1'b0;
    frame_count = '0;
    unique case (r_state)
      ST_FILL: in_ready = 1'b1;
      ST_HOLD: begin
        frame_valid = 1'b1;
        frame_count = r_cnt;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Slot counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_release) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Word storage is left unreset; the pad mux hides stale slots because
  // frame_count is zero outside HOLD.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SLOTS; i++) begin
      if (w_we[i]) r_mem[i] <= w_word;
    end
  end

  always_comb begin
    frame_data = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      frame_data[i*W +: W] = (i < int'(frame_count)) ? r_mem[i] : PAD_WORD;
    end
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
module tb_sort_frame_loader;

  localparam int NS = 32;
  localparam int WW = 29;
  localparam logic [28:0] PAD = 29'h1FFFFFFF;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [1:0]     in_cls = '0;
  logic [5:0]     in_cnt = '0;
  logic [7:0]     in_key_hi = '0;
  logic [7:0]     in_key_lo = '0;
  logic           in_last = 1'b0;
  logic           frame_valid;
  logic           frame_ready = 1'b0;
  logic [NS*WW-1:0] frame_data;
  logic [5:0]     frame_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sort_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cls      (in_cls),
    .in_cnt      (in_cnt),
    .in_key_hi   (in_key_hi),
    .in_key_lo   (in_key_lo),
    .in_last     (in_last),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [28:0] slot(input int i);
    return frame_data[i*WW +: WW];
  endfunction

  // ---------------- behavioural model ----------------
  // A frame is just the list of words accepted since the last hand-off;
  // word k carries k as its index. The model is either collecting or holding.
  logic [28:0] m_q[$];
  bit          m_hold = 1'b0;
  int          cyc = 0;
  int          frames_done = 0;
  int          m_first_acc_cyc = 0;
  int          m_last_hs_cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_hold = 1'b0;
      m_q.delete();
    end else if (!m_hold) begin
      if (in_valid) begin
        m_q.push_back({5'(m_q.size()), in_cls, in_cnt, in_key_hi, in_key_lo});
        if (m_q.size() == 1) m_first_acc_cyc = cyc;
        if (in_last || m_q.size() == NS) m_hold = 1'b1;
      end
    end else if (frame_ready) begin
      m_hold = 1'b0;
      m_q.delete();
      frames_done++;
      m_last_hs_cyc = cyc;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("frame_valid", 32'(frame_valid), 32'(m_hold));
      if (m_hold) begin
        chk("frame_count", 32'(frame_count), 32'(m_q.size()));
        for (int i = 0; i < NS; i++) begin
          chk($sformatf("slot%0d", i), 32'(slot(i)),
              32'((i < m_q.size()) ? m_q[i] : PAD));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [1:0] c, input logic [5:0] n, input logic [7:0] kh,
                      input logic [7:0] kl, input logic last, input int gap);
    bit acc;
    int waited;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_cls = c; in_cnt = n; in_key_hi = kh; in_key_lo = kl; in_last = last;
    waited = 0;
    forever begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: got no accept, want accept within 200 cycles");
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_frame(input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  logic [NS*WW-1:0] snap;
  int f0, t0, len;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    for (int i = 0; i < NS; i++) chk($sformatf("rst_slot%0d", i), 32'(slot(i)), 32'(PAD));
    @(posedge clk); #1;

    // Full frame, frame_ready low
    for (int i = 0; i < NS; i++) send(2'd0, 6'd1, 8'(i), 8'd0, 1'b0, 0);
    @(negedge clk);
    chk("full_valid", 32'(frame_valid), 32'd1);
    chk("full_count", 32'(frame_count), 32'd32);
    chk("full_slot5", 32'(slot(5)), 32'(29'b00101_00_000001_00000101_00000000));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    snap = frame_data;

    // Backpressure with a pending record that closes a 1-word frame
    @(posedge clk); #1;
    in_valid = 1'b1; in_cls = 2'd3; in_cnt = 6'd9; in_key_hi = 8'hA5; in_key_lo = 8'h5A; in_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_data_lo", frame_data[31:0], snap[31:0]);
    chk("bp_data_hi", frame_data[NS*WW-1 -: 32], snap[NS*WW-1 -: 32]);
    chk("bp_count", 32'(frame_count), 32'd32);
    @(posedge clk); #1;
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_hs", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("one_count", 32'(frame_count), 32'd1);
    chk("one_slot0", 32'(slot(0)), 32'(29'b00000_11_001001_10100101_01011010));
    @(posedge clk); #1;
    release_frame(0);

    // Short frame of 3
    for (int i = 0; i < 3; i++) send(2'(i), 6'(i+2), 8'($urandom), 8'($urandom), i == 2, 0);
    @(negedge clk);
    chk("short_count", 32'(frame_count), 32'd3);
    chk("short_idx2", 32'(slot(2) >> 24), 32'd2);
    for (int i = 3; i < NS; i++) chk($sformatf("short_pad%0d", i), 32'(slot(i)), 32'h1FFFFFFF);
    @(posedge clk); #1;
    release_frame(2);

    // Gapped input, valid pattern 1,0,0,1
    for (int i = 0; i < 20; i++)
      send(2'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), i == 19, (i % 2 == 1) ? 2 : 0);
    @(negedge clk);
    chk("gap_count", 32'(frame_count), 32'd20);
    for (int i = 0; i < 20; i++) chk($sformatf("gap_idx%0d", i), 32'(slot(i) >> 24), 32'(i));
    @(posedge clk); #1;
    release_frame(1);

    // Reset mid-frame
    for (int i = 0; i < 10; i++) send(2'd1, 6'd3, 8'(i), 8'd7, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_frame_valid", 32'(frame_valid), 32'd0);
    for (int i = 0; i < NS; i++) chk($sformatf("mr_slot%0d", i), 32'(slot(i)), 32'(PAD));
    @(posedge clk); #1;
    send(2'd2, 6'd4, 8'h11, 8'h22, 1'b1, 0);
    @(negedge clk);
    chk("mr_next_idx", 32'(slot(0) >> 24), 32'd0);
    chk("mr_next_count", 32'(frame_count), 32'd1);
    @(posedge clk); #1;
    release_frame(0);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, NS);
      for (int k = 0; k < len; k++)
        send(2'($urandom), 6'($urandom), 8'($urandom), 8'($urandom),
             (k == len-1) && ((len < NS) || ($urandom_range(0, 1) == 1)), $urandom_range(0, 2));
      release_frame($urandom_range(0, 3));
    end

    // Back-to-back frames with frame_ready held high
    frame_ready = 1'b1;
    f0 = frames_done;
    send(2'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
    t0 = m_first_acc_cyc;
    for (int i = 1; i < 2*NS; i++) send(2'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
    @(posedge clk); #1;
    frame_ready = 1'b0;
    chk("b2b_frames", 32'(frames_done - f0), 32'd2);
    chk("b2b_cycles", 32'(m_last_hs_cyc - t0 + 1), 32'd66);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_frame_loader.md
# sort_frame_loader

Upstream feeder for the 32-input `odd_even_merge_sort` network. Accepts a serial valid/ready stream of pixel records and packs each into a 29-bit sort word, stamping the arrival slot number into the index field. Buffers up to 32 words into a frame and presents the frame in parallel to the combinational sorter through a valid/ready handshake. Short frames, closed early by `in_last`, have their unused slots padded.

## Interface
- `N_SLOTS`, 32: frame depth. Fixed at 32 to match the sorter; the index field is log2 of this, 5 bits.
- `W`, 29: sort word width.
- `PAD_WORD`, 29'h1FFFFFFF: value driven on unused slots of a short frame.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input record valid.
- `in_ready`  out  1  loader can accept a record this cycle.
- `in_cls`  in  2  class label, placed in word[23:22].
- `in_cnt`  in  6  count field, placed in word[21:16].
- `in_key_hi`  in  8  primary key, placed in word[15:8].
- `in_key_lo`  in  8  secondary key, placed in word[7:0].
- `in_last`  in  1  marks this record as the last of the frame.
- `frame_valid`  out  1  a complete frame is held.
- `frame_ready`  in  1  sorter side consumes the frame.
- `frame_data`  out  N_SLOTS*W  flat frame. Slot i occupies bits [i*W +: W]; slot 0 maps to sorter input `s1`.
- `frame_count`  out  6  number of real words in the frame, 1..32.

## Operation
- Word packing: word[28:24] = slot index, 0..31, in arrival order. The remaining fields are as listed in Interface.
- FSM, two states:
  - FILL: `in_ready`=1. On accept (`in_valid` && `in_ready`), write the packed word to slot `cnt`, then `cnt` <= `cnt`+1. Go to HOLD when the accepted word has `in_last`=1 or `cnt`==31.
  - HOLD: `in_ready`=0, `frame_valid`=1. On `frame_valid` && `frame_ready`, clear `cnt` to 0 and return to FILL.
- `frame_count`: equals `cnt` in HOLD, and 32 when the frame was closed by the 32nd word. `cnt` is 6 bits and never wraps.
- Padding: `frame_data` slot i shows the stored word when i < `frame_count`, otherwise `PAD_WORD`. The mux is combinational on the registered state.
- `in_last` on the 32nd word: single close, no special handling. A frame always holds at least 1 word.
- `in_valid`=0 in FILL: hold state, no change.
- `in_valid` during HOLD: ignored (`in_ready`=0). The upstream source must hold its record until accepted.
- `frame_ready` in FILL: ignored.
- Reset at any point, including mid-frame or during HOLD: discard the partial frame and go to FILL.

## Timing
- Reset values: `in_ready`=1, `frame_valid`=0, `frame_count`=0, `frame_data` all slots = `PAD_WORD`, `cnt`=0.
- `in_ready` and `frame_valid` are decoded from the registered state only. There is no combinational path from any input to them.
- Latency: closing accept at edge N gives `frame_valid`=1 from cycle N+1.
- Frame handshake at edge M gives `in_ready`=1 from cycle M+1.
- Full-frame throughput: 33 cycles per 32 records (one HOLD cycle minimum).
- `frame_data` and `frame_count` stay stable for the whole of HOLD. The sorter output is combinational and valid while `frame_valid`=1.

## Structure
- Shared package `sort_pkg`:
  - `SORT_W`=29 and `SORT_SLOTS`=32.
  - Field LSB/width constants: IDX 24/5, CLS 22/2, CNT 16/6, KHI 8/8, KLO 0/8.
  - `SORT_PAD` constant.
  - The sort word typedef.
- One natural sub-module: `sort_key_pack`. It is purely combinational and builds the word from index and fields. The downstream serializer reuses it for unpacking constants.
- Storage: 32 x 29-bit register array with a write enable per slot.

## Test plan
- Full frame: 32 records, `in_cls`=0, `in_cnt`=1, `key_hi`=i, `key_lo`=0, `frame_ready`=0. Required: `frame_valid` rises the cycle after the 32nd accept; `frame_count`=32; slot 5 = 29'b00101_00_000001_00000101_00000000; `in_ready`=0 while held.
- Short frame: 3 records with `in_last` on the third. Required: `frame_count`=3; slots 3..31 = 29'h1FFFFFFF; slot 2 index field = 5'b00010.
- Backpressure: hold `frame_ready`=0 for 10 cycles with `in_valid`=1. Required: no accept; `frame_data` unchanged. Raise `frame_ready` for 1 cycle: `in_ready`=1 next cycle; the next frame's first word gets index 0.
- Gapped input: `in_valid` toggles 1,0,0,1 across 20 records. Required: indices contiguous 0..19 with no skipped slots.
- Reset mid-frame: after 10 accepts, assert `rst` for 1 cycle. Required: next cycle `in_ready`=1, `frame_valid`=0, all slots `PAD_WORD`; the next record gets index 0.
- Back-to-back frames: `frame_ready` held at 1 with continuous input. Required: 64 records produce exactly 2 frames, each `frame_count`=32, 66 cycles total.
